// File: rtl/register_fifo.sv
// Parametrised FIFO buffering register: write visible to a read one edge later; dataOut registered, updated one edge after an accepted read.
// No backpressure: a write to a full FIFO (no simultaneous read) or a read from an empty one is dropped and latched in a sticky error flag.
module register_fifo #(
  parameter int size            = 8,
  parameter int depth           = 8,
  parameter int almostFullLevel = depth - 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     writeEnable,
  input  logic [size-1:0]          dataIn,
  input  logic                     readEnable,
  output logic [size-1:0]          dataOut,
  output logic                     full,
  output logic                     empty,
  output logic                     almostFull,
  output logic [$clog2(depth):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int aw = $clog2(depth);
  localparam int cw = aw + 1;
  localparam logic [cw-1:0] fullCount = cw'(depth);
  localparam logic [cw-1:0] afCount   = cw'(almostFullLevel);

  logic [size-1:0] mem [depth];
  logic [aw-1:0]   wp;
  logic [aw-1:0]   rp;
  logic            rdAcc;
  logic            wrAcc;

  assign full       = (count == fullCount);
  assign empty      = (count == '0);
  assign almostFull = (count >= afCount);

  // A read on a full FIFO frees a slot in the same cycle, so the write still lands.
  assign rdAcc = readEnable && !empty;
  assign wrAcc = writeEnable && (!full || rdAcc);

  always_ff @(posedge clock) begin
    if (wrAcc && !clear) begin
      mem[wp] <= dataIn;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wp        <= '0;
      rp        <= '0;
      count     <= '0;
      dataOut   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clear) begin
      wp        <= '0;
      rp        <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wrAcc) begin
        wp <= wp + aw'(1);
      end
      if (rdAcc) begin
        rp      <= rp + aw'(1);
        dataOut <= mem[rp];
      end
      case ({wrAcc, rdAcc})
        2'b10:   count <= count + cw'(1);
        2'b01:   count <= count - cw'(1);
        default: count <= count;
      endcase
      if (writeEnable && !wrAcc) begin
        overflow <= 1'b1;
      end
      if (readEnable && !rdAcc) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_register_fifo.sv
// Directed table-driven bench for register_fifo at size=8, depth=8, almostFullLevel=7.
module tb_register_fifo;

  logic       clock = 1'b0;
  logic       reset;
  logic       clear;
  logic       writeEnable;
  logic [7:0] dataIn;
  logic       readEnable;
  logic [7:0] dataOut;
  logic       full;
  logic       empty;
  logic       almostFull;
  logic [3:0] count;
  logic       overflow;
  logic       underflow;

  register_fifo #(.size(8), .depth(8), .almostFullLevel(7)) dut (
    .clock(clock), .reset(reset), .clear(clear),
    .writeEnable(writeEnable), .dataIn(dataIn), .readEnable(readEnable),
    .dataOut(dataOut), .full(full), .empty(empty), .almostFull(almostFull),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       clr;
    logic       we;
    logic       re;
    logic [7:0] din;
    logic [7:0] dout;
    logic [3:0] cnt;
    logic       ov;
    logic       un;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic push(input logic clr, input logic we, input logic re, input logic [7:0] din,
                      input logic [7:0] dout, input int cnt, input logic ov, input logic un);
    vec_t v;
    v.clr = clr; v.we = we; v.re = re; v.din = din;
    v.dout = dout; v.cnt = 4'(cnt); v.ov = ov; v.un = un;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (step %0d): got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input int idx, input logic [7:0] dout, input logic [3:0] cnt,
                           input logic ov, input logic un);
    check("dataOut",    idx, 32'(dataOut),    32'(dout));
    check("count",      idx, 32'(count),      32'(cnt));
    check("full",       idx, 32'(full),       32'(cnt == 4'd8));
    check("empty",      idx, 32'(empty),      32'(cnt == 4'd0));
    check("almostFull", idx, 32'(almostFull), 32'(cnt >= 4'd7));
    check("overflow",   idx, 32'(overflow),   32'(ov));
    check("underflow",  idx, 32'(underflow),  32'(un));
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; writeEnable = 1'b0; readEnable = 1'b0; dataIn = 8'h00;

    // Fill 0x01..0x08
    for (int i = 1; i <= 8; i++) push(0, 1, 0, 8'(i), 8'h00, i, 0, 0);
    // Simultaneous read/write when full: oldest out, 0x55 in, count stays 8
    push(0, 1, 1, 8'h55, 8'h01, 8, 0, 0);
    // Drain: 0x02..0x08 then 0x55 last
    for (int i = 0; i < 7; i++) push(0, 0, 1, 8'h00, 8'(8'h02 + i), 7 - i, 0, 0);
    push(0, 0, 1, 8'h00, 8'h55, 0, 0, 0);
    // Simultaneous read/write when empty: write only, underflow, dataOut held
    push(0, 1, 1, 8'h33, 8'h55, 1, 0, 1);
    push(0, 0, 1, 8'h00, 8'h33, 0, 0, 1);
    push(1, 0, 0, 8'h00, 8'h33, 0, 0, 0);
    // Refill, overflow with 0xAA, read 3, write 0x10..0x12 across the wrap
    for (int i = 1; i <= 8; i++) push(0, 1, 0, 8'(i), 8'h33, i, 0, 0);
    push(0, 1, 0, 8'hAA, 8'h33, 8, 1, 0);
    for (int i = 1; i <= 3; i++) push(0, 0, 1, 8'h00, 8'(i), 8 - i, 1, 0);
    for (int i = 0; i < 3; i++) push(0, 1, 0, 8'(8'h10 + i), 8'h03, 6 + i, 1, 0);
    for (int i = 0; i < 5; i++) push(0, 0, 1, 8'h00, 8'(8'h04 + i), 7 - i, 1, 0);
    for (int i = 0; i < 3; i++) push(0, 0, 1, 8'h00, 8'(8'h10 + i), 2 - i, 1, 0);
    push(0, 0, 1, 8'h00, 8'h12, 0, 1, 1);
    // Clear priority at count=5 with sticky flags set
    for (int i = 0; i < 8; i++) push(0, 1, 0, 8'(8'h20 + i), 8'h12, i + 1, 1, 1);
    for (int i = 0; i < 3; i++) push(0, 0, 1, 8'h00, 8'(8'h20 + i), 7 - i, 1, 1);
    push(1, 1, 1, 8'h77, 8'h22, 0, 0, 0);
    push(0, 0, 1, 8'h00, 8'h22, 0, 0, 1);
    push(0, 1, 0, 8'h44, 8'h22, 1, 0, 1);
    push(0, 0, 1, 8'h00, 8'h44, 0, 0, 1);

    // Reset is asynchronous: outputs valid before any clock edge
    #2;
    check_all(-1, 8'h00, 4'd0, 1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b0;

    foreach (vecs[k]) begin
      clear = vecs[k].clr; writeEnable = vecs[k].we;
      readEnable = vecs[k].re; dataIn = vecs[k].din;
      @(posedge clock);
      #1;
      check_all(k, vecs[k].dout, vecs[k].cnt, vecs[k].ov, vecs[k].un);
    end

    // Mid-operation async reset: write two words, read one, overflow-free state, then reset between edges
    clear = 1'b0; readEnable = 1'b0; writeEnable = 1'b1; dataIn = 8'h9C;
    @(posedge clock); #1;
    dataIn = 8'h9D;
    @(posedge clock); #1;
    writeEnable = 1'b0; readEnable = 1'b1;
    @(posedge clock); #1;
    readEnable = 1'b0;
    check_all(1000, 8'h9C, 4'd1, 1'b0, 1'b1);
    #1;
    reset = 1'b1;
    #1;
    check_all(1001, 8'h00, 4'd0, 1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    // Stored 0x9D was lost: a read now underflows and dataOut stays 0
    readEnable = 1'b1;
    @(posedge clock); #1;
    readEnable = 1'b0;
    check_all(1002, 8'h00, 4'd0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
